// File: rtl/framebuffer_byte_writer.sv
// Purpose : write side of the dual-port framebuffer; turns a row-major pixel byte stream into
//           port-A byte writes so each port-B word holds {all subpanels x all colour bytes}.
// Latency : 1 cycle from an accepted byte to its port-A write (wr_en/wr_addr/wr_data registered).
// Backpressure: in_ready is high for the whole frame (STREAM) and low in IDLE; the RAM never stalls.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   frame_start           pulse that (re)starts a frame at pixel (row 0, col 0), byte 0
//   in_data/in_valid/in_ready   8-bit byte stream, valid/ready handshake
//   wr_en/wr_addr/wr_data port-A byte write; address/data hold between writes
//   frame_done            one-cycle pulse coincident with the final write of a frame
//   frame_abort           one-cycle pulse when a restart discards a partially received frame
//   busy                  high while a frame is being streamed
module framebuffer_byte_writer #(
  parameter int PIXEL_WIDTH      = 64,
  parameter int PIXEL_HEIGHT     = 32,
  parameter int PIXEL_HALFHEIGHT = 16,
  parameter int BYTES_PER_PIXEL  = 2,
  localparam int SPB  = $clog2(PIXEL_HEIGHT / PIXEL_HALFHEIGHT),
  localparam int CB   = $clog2(BYTES_PER_PIXEL),
  localparam int RB   = $clog2(PIXEL_HALFHEIGHT),
  localparam int COLB = $clog2(PIXEL_WIDTH),
  localparam int AW   = SPB + CB + RB + COLB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_done,
  output logic          frame_abort,
  output logic          busy
);

  // Terminal values of each cursor. BYTES_PER_PIXEL need not be a power of two,
  // so byte_idx wraps by compare rather than by overflow.
  localparam logic [CB-1:0]   BYTE_LAST = CB'(BYTES_PER_PIXEL - 1);
  localparam logic [COLB-1:0] COL_LAST  = COLB'(PIXEL_WIDTH - 1);
  localparam logic [RB-1:0]   ROW_LAST  = RB'(PIXEL_HALFHEIGHT - 1);
  localparam logic [SPB-1:0]  SP_LAST   = SPB'(PIXEL_HEIGHT / PIXEL_HALFHEIGHT - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Position of the next byte to be accepted.
  logic [CB-1:0]   byte_idx,    byte_idx_nxt;
  logic [COLB-1:0] col,         col_nxt;
  logic [RB-1:0]   row_in_half, row_in_half_nxt;
  logic [SPB-1:0]  subpanel,    subpanel_nxt;

  // Set once the current frame has delivered at least one byte; a restart
  // only counts as an abort when there was something to throw away.
  logic frame_has_data, frame_has_data_nxt;

  logic accept;       // handshake completes this cycle
  logic accept_wr;    // handshake that actually produces a write
  logic last_byte;    // cursor sits on the final byte of the frame
  logic abort_nxt;
  logic [AW-1:0] cur_addr;

  // Word address (row_in_half, col) in the upper bits so port B reads one
  // pixel column of every subpanel at once; lane = {subpanel, byte_idx}.
  assign cur_addr = {row_in_half, col, subpanel, byte_idx};

  assign in_ready = (state == ST_STREAM);
  assign busy     = (state == ST_STREAM);
  assign accept   = in_valid & in_ready;

  assign last_byte = (byte_idx == BYTE_LAST) && (col == COL_LAST) &&
                     (row_in_half == ROW_LAST) && (subpanel == SP_LAST);

  always_comb begin
    state_nxt          = state;
    byte_idx_nxt       = byte_idx;
    col_nxt            = col;
    row_in_half_nxt    = row_in_half;
    subpanel_nxt       = subpanel;
    frame_has_data_nxt = frame_has_data;
    abort_nxt          = 1'b0;
    // A restart in the same cycle as a handshake drops that byte.
    accept_wr          = accept & ~frame_start;

    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (frame_start) begin
          state_nxt = ST_STREAM;
        end else if (accept && last_byte) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (frame_start) begin
      abort_nxt          = (state == ST_STREAM) && frame_has_data;
      byte_idx_nxt       = '0;
      col_nxt            = '0;
      row_in_half_nxt    = '0;
      subpanel_nxt       = '0;
      frame_has_data_nxt = 1'b0;
    end else if (accept_wr) begin
      // Odometer: byte -> column -> row within subpanel -> subpanel. The last
      // byte rolls every digit over, leaving all cursors at zero for the next frame.
      frame_has_data_nxt = ~last_byte;
      if (byte_idx == BYTE_LAST) begin
        byte_idx_nxt = '0;
        if (col == COL_LAST) begin
          col_nxt = '0;
          if (row_in_half == ROW_LAST) begin
            row_in_half_nxt = '0;
            if (subpanel == SP_LAST) begin
              subpanel_nxt = '0;
            end else begin
              subpanel_nxt = subpanel + 1'b1;
            end
          end else begin
            row_in_half_nxt = row_in_half + 1'b1;
          end
        end else begin
          col_nxt = col + 1'b1;
        end
      end else begin
        byte_idx_nxt = byte_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      byte_idx       <= '0;
      col            <= '0;
      row_in_half    <= '0;
      subpanel       <= '0;
      frame_has_data <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      frame_done     <= 1'b0;
      frame_abort    <= 1'b0;
    end else begin
      state          <= state_nxt;
      byte_idx       <= byte_idx_nxt;
      col            <= col_nxt;
      row_in_half    <= row_in_half_nxt;
      subpanel       <= subpanel_nxt;
      frame_has_data <= frame_has_data_nxt;
      wr_en          <= accept_wr;
      frame_done     <= accept_wr & last_byte;
      frame_abort    <= abort_nxt;
      // Address/data hold their last value between writes.
      if (accept_wr) begin
        wr_addr <= cur_addr;
        wr_data <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_byte_writer.sv
module tb_framebuffer_byte_writer;

  localparam int W = 4;
  localparam int H = 4;
  localparam int HH = 2;
  localparam int NSP = H / HH;
  localparam int FRAME2 = W * H * 2;
  localparam int FRAME3 = W * H * 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_en, frame_done, frame_abort, busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  logic       frame_start_3 = 1'b0;
  logic [7:0] in_data_3 = 8'h00;
  logic       in_valid_3 = 1'b0;
  logic       in_ready_3, wr_en_3, frame_done_3, frame_abort_3, busy_3;
  logic [5:0] wr_addr_3;
  logic [7:0] wr_data_3;

  always #5 clk = ~clk;

  framebuffer_byte_writer #(.PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .PIXEL_HALFHEIGHT(HH),
                            .BYTES_PER_PIXEL(2)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .frame_abort(frame_abort), .busy(busy));

  framebuffer_byte_writer #(.PIXEL_WIDTH(W), .PIXEL_HEIGHT(H), .PIXEL_HALFHEIGHT(HH),
                            .BYTES_PER_PIXEL(3)) dut3 (
    .clk(clk), .reset(reset), .frame_start(frame_start_3), .in_data(in_data_3),
    .in_valid(in_valid_3), .in_ready(in_ready_3), .wr_en(wr_en_3), .wr_addr(wr_addr_3),
    .wr_data(wr_data_3), .frame_done(frame_done_3), .frame_abort(frame_abort_3), .busy(busy_3));

  int checks = 0;
  int failures = 0;

  // Reference model: just "is a frame open" and "how many bytes of it arrived".
  bit         m_active = 0;
  int         m_k = 0;
  logic [4:0] m_addr = '0;
  logic [7:0] m_data = '0;

  typedef struct {
    logic fs; logic v; logic [7:0] d;
    logic we; logic [4:0] addr; logic [7:0] data; logic done; logic abort; logic rdy;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // Byte k of a row-major frame: pixel = k/bpp, row = pixel/W, col = pixel%W,
  // row splits into subpanel/row_in_half; word = row_in_half*W+col, lane = subpanel*2^cb+byte.
  function automatic int addr_of(input int k, input int bpp, input int cb);
    int pix, b, row, col, sp, rih;
    pix = k / bpp;  b = k % bpp;
    row = pix / W;  col = pix % W;
    sp  = row / HH; rih = row % HH;
    return ((rih * W + col) * NSP + sp) * (1 << cb) + b;
  endfunction

  task automatic do_reset();
    reset = 1'b1; frame_start = 1'b0; in_valid = 1'b1; in_data = 8'($urandom);
    @(posedge clk); #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_abort", 32'(frame_abort), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    reset = 1'b0;
    m_active = 0; m_k = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic cycle(input logic fs, input logic v, input logic [7:0] d);
    logic e_we, e_done, e_abort;
    frame_start = fs; in_valid = v; in_data = d;
    chk("in_ready_pre", 32'(in_ready), 32'(m_active));
    e_we = 0; e_done = 0; e_abort = 0;
    if (fs) begin
      e_abort = m_active && (m_k > 0);
      m_k = 0; m_active = 1;
    end else if (v && m_active) begin
      e_we = 1;
      m_addr = 5'(addr_of(m_k, 2, 1));
      m_data = d;
      m_k++;
      if (m_k == FRAME2) begin
        e_done = 1; m_active = 0; m_k = 0;
      end
    end
    @(posedge clk); #1;
    chk("wr_en", 32'(wr_en), 32'(e_we));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", 32'(wr_data), 32'(m_data));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("frame_abort", 32'(frame_abort), 32'(e_abort));
    chk("busy", 32'(busy), 32'(m_active));
    chk("in_ready_post", 32'(in_ready), 32'(m_active));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //            fs v  d      we addr data   done abort rdy
    vecs[0]  = '{0, 1, 8'hAA, 0, 0, 8'h00, 0, 0, 0};
    vecs[1]  = '{0, 1, 8'hBB, 0, 0, 8'h00, 0, 0, 0};
    vecs[2]  = '{1, 1, 8'hCC, 0, 0, 8'h00, 0, 0, 1};  // start in IDLE: no accept, no abort
    vecs[3]  = '{0, 1, 8'h10, 1, 0, 8'h10, 0, 0, 1};
    vecs[4]  = '{0, 0, 8'h11, 0, 0, 8'h10, 0, 0, 1};  // idle cycle: hold
    vecs[5]  = '{0, 1, 8'h11, 1, 1, 8'h11, 0, 0, 1};
    vecs[6]  = '{0, 1, 8'h12, 1, 4, 8'h12, 0, 0, 1};
    vecs[7]  = '{0, 1, 8'h13, 1, 5, 8'h13, 0, 0, 1};
    vecs[8]  = '{1, 1, 8'h14, 0, 5, 8'h13, 0, 1, 1};  // restart wins over byte
    vecs[9]  = '{0, 1, 8'h20, 1, 0, 8'h20, 0, 0, 1};
    vecs[10] = '{1, 0, 8'h00, 0, 0, 8'h20, 0, 1, 1};
    vecs[11] = '{1, 0, 8'h00, 0, 0, 8'h20, 0, 0, 1};  // nothing received since: no abort
    vecs[12] = '{0, 1, 8'h30, 1, 0, 8'h30, 0, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 1: idle with valid held high
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'($urandom));

    // Table vectors
    do_reset();
    for (int i = 0; i < 13; i++) begin
      frame_start = vecs[i].fs; in_valid = vecs[i].v; in_data = vecs[i].d;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].we));
      chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_abort", i), 32'(frame_abort), 32'(vecs[i].abort));
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
    end
    do_reset();

    // 2: contiguous frame 0x00..0x1F
    cycle(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < FRAME2; k++) begin
      cycle(1'b0, 1'b1, 8'(k));
      if (k == 2)  chk("t2_col1_addr", 32'(wr_addr), 4);
      if (k == 16) chk("t2_row2_addr", 32'(wr_addr), 2);
      if (k == 31) begin
        chk("t2_last_addr", 32'(wr_addr), 31);
        chk("t2_last_done", 32'(frame_done), 1);
      end
    end
    cycle(1'b0, 1'b1, 8'hEE);

    // 3: same frame with random valid gaps
    cycle(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 600 && m_active; c++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 8'(m_k));
    chk("t3_frame_completed", 32'(m_active), 0);

    // 4: restart after 5 bytes, then a full frame
    cycle(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'($urandom));
    cycle(1'b1, 1'b0, 8'h00);
    chk("t4_abort", 32'(frame_abort), 1);
    cycle(1'b0, 1'b1, 8'h5A);
    chk("t4_restart_addr", 32'(wr_addr), 0);
    for (int k = 1; k < FRAME2; k++) cycle(1'b0, 1'b1, 8'($urandom));
    chk("t4_done", 32'(frame_done), 1);

    // 5: restart coincident with a byte
    cycle(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'($urandom));
    cycle(1'b1, 1'b1, 8'h77);
    chk("t5_no_write", 32'(wr_en), 0);
    cycle(1'b0, 1'b1, 8'h78);
    chk("t5_restart_addr", 32'(wr_addr), 0);

    // 6: reset mid-frame at byte 10
    do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 8'($urandom));
    do_reset();
    cycle(1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 8'h55);
    chk("t6_restart_addr", 32'(wr_addr), 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 3) do_reset();
      else cycle(1'(r < 13), 1'($urandom_range(0, 1)), 8'($urandom));
    end
    do_reset();

    // BPP=3 instance: lane 3 of each word is never written
    frame_start_3 = 1'b1;
    @(posedge clk); #1;
    frame_start_3 = 1'b0;
    chk("bpp3_ready", 32'(in_ready_3), 1);
    for (int k = 0; k < FRAME3; k++) begin
      in_valid_3 = 1'b1; in_data_3 = 8'(k + 100);
      @(posedge clk); #1;
      chk("bpp3_wr_en", 32'(wr_en_3), 1);
      chk("bpp3_wr_addr", 32'(wr_addr_3), 32'(addr_of(k, 3, 2)));
      chk("bpp3_wr_data", 32'(wr_data_3), 32'(k + 100));
      chk("bpp3_lane3", 32'(wr_addr_3[1:0] == 2'd3), 0);
      chk("bpp3_done", 32'(frame_done_3), 32'(k == FRAME3 - 1));
      if (k < 3) chk("bpp3_pix0_addr", 32'(wr_addr_3), 32'(k));
    end
    @(posedge clk); #1;
    chk("bpp3_idle_wr_en", 32'(wr_en_3), 0);
    chk("bpp3_idle_ready", 32'(in_ready_3), 0);
    in_valid_3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
